// File: rtl/br_mask_tracker.sv
// br_mask_tracker: tracks the in-flight speculative branches for a dispatch stage.
// For each branch it remembers which older branches were live when it was
// allocated, so that a mispredict can kill every branch that depends on it.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   id_br_alloc_i/tag   dispatch allocates a one-hot branch tag
//   ex_br_resolve_i/tag resolving branch; ex_br_mispred_i marks a mispredict
//   bmt_br_mask_o       registered live-tag mask; depth/full derived from it
//   bmt_clear_mask_o    one-cycle pulse with the tag that resolved correctly
//   bmt_squash_mask_o   one-cycle pulse with the tags killed by a mispredict
//   bmt_recovery_o      one-cycle recovery pulse on a mispredict
//   bmt_err_o           sticky protocol-error flag
//
// Latency: every output is registered, one cycle after the triggering event.
// Backpressure: none. Illegal requests are dropped and latch bmt_err_o.

`ifndef BR_TAG_W
`define BR_TAG_W 4
`endif
`ifndef BR_DEPTH_W
`define BR_DEPTH_W 3
`endif

module br_mask_tracker (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_br_alloc_i,
  input  logic [`BR_TAG_W-1:0]   id_br_tag_i,
  input  logic                   ex_br_resolve_i,
  input  logic [`BR_TAG_W-1:0]   ex_br_tag_i,
  input  logic                   ex_br_mispred_i,
  output logic [`BR_TAG_W-1:0]   bmt_br_mask_o,
  output logic [`BR_TAG_W-1:0]   bmt_clear_mask_o,
  output logic [`BR_TAG_W-1:0]   bmt_squash_mask_o,
  output logic                   bmt_recovery_o,
  output logic [`BR_DEPTH_W-1:0] bmt_br_depth_o,
  output logic                   bmt_full_o,
  output logic                   bmt_err_o
);

  localparam int TW = `BR_TAG_W;
  localparam int DW = `BR_DEPTH_W;

  typedef enum logic {NORMAL = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state_r, state_n;
  logic [TW-1:0]   live_r, live_n;
  logic [TW-1:0]   dep_r [TW];
  logic [TW-1:0]   dep_n [TW];
  logic [TW-1:0]   clear_r, squash_r;
  logic            recovery_r, err_r;

  logic [TW-1:0]   clr_tag, squash;
  logic [DW-1:0]   depth;
  logic            full;
  logic            res_live, correct, mispred;
  logic            alloc_try, alloc_bad, alloc_ok, err_n;

  assign full = &live_r;

  always_comb begin
    depth = '0;
    for (int i = 0; i < TW; i++) begin
      depth = depth + DW'(live_r[i]);
    end
  end

  always_comb begin
    // A resolve only counts if it names exactly one tag that is live now.
    res_live = ex_br_resolve_i && $onehot(ex_br_tag_i) && (|(ex_br_tag_i & live_r));
    correct  = res_live && !ex_br_mispred_i;
    mispred  = res_live && ex_br_mispred_i;
    clr_tag  = correct ? ex_br_tag_i : '0;

    // Kill the mispredicted branch and every younger branch that saw it live.
    squash = '0;
    if (mispred) begin
      squash = ex_br_tag_i;
      for (int j = 0; j < TW; j++) begin
        if (|(dep_r[j] & ex_br_tag_i)) squash[j] = 1'b1;
      end
    end

    // FLUSH-cycle and same-cycle-mispredict allocs are wrong-path: silent drop.
    alloc_try = id_br_alloc_i && (state_r == NORMAL) && !mispred;
    alloc_bad = alloc_try &&
                (!$onehot(id_br_tag_i) || full || (|(id_br_tag_i & live_r)));
    alloc_ok  = alloc_try && !alloc_bad;

    err_n = err_r || alloc_bad || (ex_br_resolve_i && !res_live);

    live_n = (live_r & ~clr_tag & ~squash) | (alloc_ok ? id_br_tag_i : '0);

    for (int j = 0; j < TW; j++) begin
      dep_n[j] = dep_r[j] & ~clr_tag & ~squash;
      if (squash[j]) dep_n[j] = '0;
      // New branch depends on everything live except a tag retiring this cycle.
      if (alloc_ok && id_br_tag_i[j]) dep_n[j] = live_r & ~clr_tag;
    end

    // FLUSH lasts one cycle; a fresh mispredict starts a new one.
    state_n = mispred ? FLUSH : NORMAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= NORMAL;
      live_r     <= '0;
      clear_r    <= '0;
      squash_r   <= '0;
      recovery_r <= 1'b0;
      err_r      <= 1'b0;
      for (int j = 0; j < TW; j++) dep_r[j] <= '0;
    end else begin
      state_r    <= state_n;
      live_r     <= live_n;
      clear_r    <= clr_tag;
      squash_r   <= squash;
      recovery_r <= mispred;
      err_r      <= err_n;
      for (int j = 0; j < TW; j++) dep_r[j] <= dep_n[j];
    end
  end

  assign bmt_br_mask_o     = live_r;
  assign bmt_clear_mask_o  = clear_r;
  assign bmt_squash_mask_o = squash_r;
  assign bmt_recovery_o    = recovery_r;
  assign bmt_br_depth_o    = depth;
  assign bmt_full_o        = full;
  assign bmt_err_o         = err_r;

endmodule

// File: doc/br_mask_tracker.md
BR_MASK_TRACKER -- requirements
Module: br_mask_tracker

Interface
REQ-001 The block SHALL use the include-file macros `BR_TAG_W` (default 4, one-hot tag width and number of in-flight branches) and `BR_DEPTH_W` (default 3, width of the live-branch count).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_br_alloc_i  input  1  dispatch allocates a speculative branch this cycle.
REQ-005 id_br_tag_i  input  BR_TAG_W  one-hot tag of the allocated branch.
REQ-006 ex_br_resolve_i  input  1  a branch resolves this cycle.
REQ-007 ex_br_tag_i  input  BR_TAG_W  one-hot tag of the resolving branch.
REQ-008 ex_br_mispred_i  input  1  the resolving branch mispredicted; qualified by ex_br_resolve_i.
REQ-009 bmt_br_mask_o  output  BR_TAG_W  live-tag mask, attached to each dispatched instruction.
REQ-010 bmt_clear_mask_o  output  BR_TAG_W  one-cycle pulse, tag resolved correct.
REQ-011 bmt_squash_mask_o  output  BR_TAG_W  one-cycle pulse, tags killed by a mispredict.
REQ-012 bmt_recovery_o  output  1  one-cycle recovery pulse.
REQ-013 bmt_br_depth_o  output  BR_DEPTH_W  popcount of the live mask.
REQ-014 bmt_full_o  output  1  depth == BR_TAG_W.
REQ-015 bmt_err_o  output  1  sticky protocol-error flag.

Function
REQ-016 State SHALL be:
- live_r[BR_TAG_W]
- dep_r[i][BR_TAG_W] per tag i: the live mask at allocation, i.e. the older branches
- FSM state_r in {NORMAL, FLUSH}
REQ-017 Alloc, NORMAL, not full, tag not live, no mispredict this cycle: next cycle live_r |= id_br_tag_i, and that tag's dep_r = live_r with any same-cycle correct-resolved tag removed.
REQ-018 Correct resolve (resolve=1, mispred=0) of a live tag: next cycle that bit SHALL clear in live_r and in every dep_r; bmt_clear_mask_o = ex_br_tag_i for exactly one cycle.
REQ-019 Mispredict of a live tag t: squash = t OR every j with dep_r[j] containing t.
REQ-020 On a mispredict, next cycle live_r &= ~squash, dep_r of squashed tags SHALL zero, bmt_squash_mask_o = squash and bmt_recovery_o = 1 for one cycle, and state_r SHALL go to FLUSH.
REQ-021 FLUSH SHALL last exactly one cycle and then return to NORMAL; allocs in FLUSH SHALL be ignored without error.
REQ-022 Alloc in the same cycle as a mispredict SHALL be dropped as wrong-path, without error.
REQ-023 Resolves in FLUSH SHALL be processed normally if the tag is still live.
REQ-024 Resolve of a non-live tag SHALL be ignored, no pulse, and set bmt_err_o.
REQ-025 Alloc when full, or of an already-live tag, SHALL be ignored and set bmt_err_o.
REQ-026 Alloc or resolve tag not one-hot (zero or multiple bits) SHALL be ignored and set bmt_err_o.
REQ-027 Same-tag alloc and resolve in one cycle: the resolve of the old instance applies and the alloc is an error, since the tag is live at the cycle start.
REQ-028 bmt_br_mask_o, bmt_br_depth_o and bmt_full_o SHALL reflect registered live_r, i.e. one-cycle latency from an alloc or resolve; no combinational input-to-output paths.
REQ-029 All pulse outputs SHALL be registered and deassert the cycle after assertion unless re-triggered.
REQ-030 Depth SHALL never exceed BR_TAG_W and never underflow.

Reset
REQ-031 On rst: live_r=0, all dep_r=0, state_r=NORMAL.
REQ-032 On rst, all outputs SHALL be 0, including bmt_err_o; rst overrides any same-cycle alloc or resolve.
REQ-033 rst asserted during FLUSH SHALL return the block to NORMAL with no pending pulses.

Verification
REQ-034 Alloc 0001, 0010, 0100 on consecutive cycles -> mask 0111, depth 3, full 0; one more alloc 1000 -> mask 1111, full 1.
REQ-035 From 0111, mispredict 0010 -> squash_mask 0110 and recovery 1 for one cycle, then mask 0001, depth 1.
REQ-036 From 0011, correct resolve 0001 plus alloc 0100 in the same cycle -> clear_mask 0001, mask 0110, dep[0100]=0010.
REQ-037 From 1111 (full), alloc 0001 -> mask unchanged, err 1 (sticky); resolve of non-live tag after mispredict -> no pulse, err stays 1.
REQ-038 Mispredict 0001 with alloc 0010 in the same cycle -> alloc dropped; the next-cycle alloc in FLUSH is ignored; the cycle after, alloc 0010 -> accepted, err 0.
REQ-039 Alloc three tags, assert rst mid-FLUSH -> all outputs 0 next cycle; a following alloc is accepted normally.
